// File: rtl/iob_2p_assim_fifo_ctrl_r_big.sv
// FIFO controller placed in front of an asymmetric dual-port RAM with a narrow write port and a wide read port.
// It tracks occupancy in narrow words and returns each wide read word one cycle after the read is accepted.
module iob_2p_assim_fifo_ctrl_r_big #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int W_ADDR_W = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              w_req,
  input  logic [W_DATA_W-1:0]               w_data,
  output logic                              w_full,
  output logic                              w_ovf,
  input  logic                              r_req,
  output logic [R_DATA_W-1:0]               r_data,
  output logic                              r_valid,
  output logic                              r_empty,
  output logic                              r_unf,
  output logic [W_ADDR_W:0]                 level,
  output logic                              mem_w_en,
  output logic [W_ADDR_W-1:0]               mem_w_addr,
  output logic [W_DATA_W-1:0]               mem_w_data,
  output logic                              mem_r_en,
  output logic [W_ADDR_W-$clog2(R_DATA_W/W_DATA_W)-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0]               mem_r_data
);

  localparam int RATIO    = R_DATA_W / W_DATA_W;
  localparam int L2R      = $clog2(RATIO);
  localparam int R_ADDR_W = W_ADDR_W - L2R;

  localparam logic [W_ADDR_W:0] DEPTH   = {1'b1, {W_ADDR_W{1'b0}}};
  localparam logic [W_ADDR_W:0] RATIO_L = (W_ADDR_W+1)'(RATIO);

  // The extra MSB on each pointer separates a full FIFO from an empty one.
  logic [W_ADDR_W:0] wptr;
  logic [R_ADDR_W:0] rptr;
  logic [W_ADDR_W:0] rptr_narrow;
  logic              w_acc;
  logic              r_acc;

  // The read pointer counts wide words, so scale it to narrow units before subtracting.
  assign rptr_narrow = (W_ADDR_W+1)'(rptr) << L2R;
  assign level       = wptr - rptr_narrow;

  assign w_full  = (level == DEPTH);
  assign r_empty = (level < RATIO_L);

  // Both accept decisions use the flags at the start of the cycle.
  // A read cannot free space for a write in the same cycle, and a write cannot complete a wide word for a read in the same cycle.
  assign w_acc = w_req & ~w_full;
  assign r_acc = r_req & ~r_empty;

  assign mem_w_en   = w_acc;
  assign mem_w_addr = wptr[W_ADDR_W-1:0];
  assign mem_w_data = w_data;

  assign mem_r_en   = r_acc;
  assign mem_r_addr = rptr[R_ADDR_W-1:0];

  assign r_data = mem_r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      r_valid <= 1'b0;
      w_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + 1'b1;
      if (r_acc) rptr <= rptr + 1'b1;
      r_valid <= r_acc;
      w_ovf   <= w_req & w_full;
      r_unf   <= r_req & r_empty;
    end
  end

endmodule

// File: tb/tb_iob_2p_assim_fifo_ctrl_r_big.sv
// Testbench for iob_2p_assim_fifo_ctrl_r_big: directed and random traffic are compared against a byte-queue model.
// A small asymmetric RAM model supplies the wide read data.
module tb_iob_2p_assim_fifo_ctrl_r_big;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_req;
  logic [7:0]  w_data;
  logic        w_full;
  logic        w_ovf;
  logic        r_req;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_empty;
  logic        r_unf;
  logic [4:0]  level;
  logic        mem_w_en;
  logic [3:0]  mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        mem_r_en;
  logic [1:0]  mem_r_addr;
  logic [31:0] mem_r_data;

  iob_2p_assim_fifo_ctrl_r_big dut (
    .clk(clk), .rst(rst),
    .w_req(w_req), .w_data(w_data), .w_full(w_full), .w_ovf(w_ovf),
    .r_req(r_req), .r_data(r_data), .r_valid(r_valid), .r_empty(r_empty), .r_unf(r_unf),
    .level(level),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  // Asymmetric RAM: 16 bytes written one at a time, read four at a time, with registered output.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= {ram[{mem_r_addr, 2'd3}], ram[{mem_r_addr, 2'd2}],
                                 ram[{mem_r_addr, 2'd1}], ram[{mem_r_addr, 2'd0}]};
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stored bytes kept in order, plus running counts of accepted writes and reads.
  logic [7:0]  mq[$];
  logic [31:0] exp_q[$];
  int          wr_total;
  int          rd_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every r_valid must match the oldest outstanding expected wide word.
  always @(negedge clk) begin
    if (!rst && r_valid) begin
      if (exp_q.size() == 0) chk("r_valid_unexpected", 32'(r_valid), 32'd0);
      else chk("r_data", r_data, exp_q.pop_front());
    end
  end

  // Runs one clock cycle. The bench sets the inputs, checks the combinational outputs at the falling edge, updates the model, and checks the registered pulses just after the rising edge.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
    int          cnt;
    logic        full_m, empty_m, wacc, racc;
    logic [31:0] word;
    w_req = wr; w_data = wd; r_req = rd;
    @(negedge clk);
    cnt     = mq.size();
    full_m  = (cnt == 16);
    empty_m = (cnt < 4);
    wacc    = wr && !full_m;
    racc    = rd && !empty_m;
    chk("level",    32'(level),    32'(cnt));
    chk("w_full",   32'(w_full),   32'(full_m));
    chk("r_empty",  32'(r_empty),  32'(empty_m));
    chk("mem_w_en", 32'(mem_w_en), 32'(wacc));
    chk("mem_r_en", 32'(mem_r_en), 32'(racc));
    if (wacc) begin
      chk("mem_w_addr", 32'(mem_w_addr), 32'(wr_total % 16));
      chk("mem_w_data", 32'(mem_w_data), 32'(wd));
    end
    if (racc) chk("mem_r_addr", 32'(mem_r_addr), 32'(rd_total % 4));
    if (racc) begin
      word = {mq[3], mq[2], mq[1], mq[0]};
      repeat (4) void'(mq.pop_front());
      exp_q.push_back(word);
      rd_total++;
    end
    if (wacc) begin
      mq.push_back(wd);
      wr_total++;
    end
    @(posedge clk);
    #1;
    chk("w_ovf", 32'(w_ovf), 32'(wr && full_m));
    chk("r_unf", 32'(r_unf), 32'(rd && empty_m));
    w_req = 1'b0; r_req = 1'b0;
  endtask

  // Asserts reset at the current time and checks its asynchronous effect right away.
  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    exp_q.delete();
    wr_total = 0;
    rd_total = 0;
    #1;
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_r_empty", 32'(r_empty), 32'd1);
    chk("rst_w_full",  32'(w_full),  32'd0);
    chk("rst_w_ovf",   32'(w_ovf),   32'd0);
    chk("rst_r_unf",   32'(r_unf),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] seq4 [4];
    w_req = 1'b0; r_req = 1'b0; w_data = '0;
    do_reset();

    // Basic packing: the first byte written lands in the LSBs of the wide word.
    seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) step(1'b1, seq4[i], 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Underflow from empty, then with a partial wide word present.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Fill to full, then overflow.
    for (int i = 3; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h10, 1'b0);

    // At full, a same-cycle write and read: the write is rejected and the read is accepted. Next cycle both are accepted.
    step(1'b1, 8'h55, 1'b1);
    step(1'b1, 8'h66, 1'b1);
    while (mq.size() >= 4) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Stream of 40 writes, with a read whenever the model says a wide word is available; the pointers wrap.
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(0, 255)), mq.size() >= 4);
    while (mq.size() >= 4) step(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < 40);
    while (mq.size() >= 4) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset while a read is in flight: the pending r_valid must be dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0);
    w_req = 1'b0; r_req = 1'b1;
    @(posedge clk);
    #1;
    r_req = 1'b0;
    do_reset();
    seq4 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) step(1'b1, seq4[i], 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
